// File: rtl/td4_if.sv
// td4_if: ROM fetch and I/O port bundle of the TD4 core; halted exists only with TD4_HALT_DETECT_EN
interface td4_if;
    logic [3:0] rom_addr;
    logic [7:0] rom_data;
    logic [3:0] in_port;
    logic [3:0] out_port;
    logic       out_strobe;
`ifdef TD4_HALT_DETECT_EN
    logic       halted;
    modport master (output rom_addr, out_port, out_strobe, halted, input rom_data, in_port);
    modport slave  (input rom_addr, out_port, out_strobe, halted, output rom_data, in_port);
`else
    modport master (output rom_addr, out_port, out_strobe, input rom_data, in_port);
    modport slave  (input rom_addr, out_port, out_strobe, output rom_data, in_port);
`endif
endinterface

// File: rtl/td4_core.sv
// td4_core: single-cycle 4-bit TD4 CPU; optional self-jump halt detection under TD4_HALT_DETECT_EN
module td4_core #(
    parameter logic [3:0] RESET_PC = 4'h0
) (
    input  logic  clk,
    input  logic  n_reset,
    td4_if.master bus
);
    logic [3:0] a, b, pc, op, im, src;
    logic [4:0] sum;
    logic       c, wa, wb, wo, jmp, run;
    assign op = bus.rom_data[7:4];
    assign im = bus.rom_data[3:0];
    assign bus.rom_addr = pc;
    // decode: pick the adder source and the single destination of the instruction
    always_comb begin
        src = 4'h0;
        wa  = 1'b0;
        wb  = 1'b0;
        wo  = 1'b0;
        jmp = 1'b0;
        case (op)
            4'b0000: begin src = a;           wa = 1'b1; end
            4'b0101: begin src = b;           wb = 1'b1; end
            4'b0011: wa = 1'b1;
            4'b0111: wb = 1'b1;
            4'b0001: begin src = b;           wa = 1'b1; end
            4'b0100: begin src = a;           wb = 1'b1; end
            4'b0010: begin src = bus.in_port; wa = 1'b1; end
            4'b0110: begin src = bus.in_port; wb = 1'b1; end
            4'b1001: begin src = b;           wo = 1'b1; end
            4'b1011: wo = 1'b1;
            4'b1111: jmp = 1'b1;
            4'b1110: jmp = !c;
            default: ;
        endcase
        sum = {1'b0, src} + {1'b0, im};
    end
`ifdef TD4_HALT_DETECT_EN
    logic halted;
    assign bus.halted = halted;
    assign run = !halted;
    // a taken jump onto itself can never leave, so latch halted until reset
    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) halted <= 1'b0;
        else if (jmp && im == pc) halted <= 1'b1;
    end
`else
    assign run = 1'b1;
`endif
    // architectural state update; carry is rewritten by every executed instruction
    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            pc             <= RESET_PC;
            a              <= 4'h0;
            b              <= 4'h0;
            c              <= 1'b0;
            bus.out_port   <= 4'h0;
            bus.out_strobe <= 1'b0;
        end else begin
            bus.out_strobe <= run && wo;
            if (run) begin
                pc <= jmp ? im : pc + 4'h1;
                c  <= sum[4];
                if (wa) a <= sum[3:0];
                if (wb) b <= sum[3:0];
                if (wo) bus.out_port <= sum[3:0];
            end
        end
    end
endmodule
